// File: rtl/param_shift_pkg.sv
// Shared mode encodings and FSM state type for the parameterised shift register.
package param_shift_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_HOLD = 3'b000;
   localparam mode_t MODE_SHL  = 3'b001;
   localparam mode_t MODE_SHR  = 3'b010;
   localparam mode_t MODE_ROL  = 3'b011;
   localparam mode_t MODE_ROR  = 3'b100;
   localparam mode_t MODE_ASR  = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One-step next-value logic for the shift register; purely combinational.
module shift_step
   import param_shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   input  mode_t            mode_i,
   input  logic             sin_i,
   output logic [WIDTH-1:0] q_o
);

   always_comb begin
      q_o = q_i;
      case (mode_i)
         MODE_HOLD: q_o = q_i;
         MODE_SHL:  q_o = {q_i[WIDTH-2:0], sin_i};
         MODE_SHR:  q_o = {sin_i, q_i[WIDTH-1:1]};
         MODE_ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
         MODE_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
         MODE_ASR:  q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
         // 110 and 111 are reserved and behave as hold
         default:   q_o = q_i;
      endcase
   end

endmodule

// File: rtl/param_shift_reg.sv
// Parameterised shift/rotate register with single-step and counted burst operation.
module param_shift_reg
   import param_shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             sin,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   output logic [WIDTH-1:0] q,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_t            mode_lat_q, mode_lat_d;
   state_e           state_q, state_d;

   mode_t            step_mode;
   logic [WIDTH-1:0] step_q;

   // During a burst the latched mode drives the step; otherwise the live input does
   assign step_mode = (state_q == SHIFT) ? mode_lat_q : mode_t'(mode);

   shift_step #(
      .WIDTH (WIDTH)
   ) u_shift_step (
      .q_i    (q_q),
      .mode_i (step_mode),
      .sin_i  (sin),
      .q_o    (step_q)
   );

   always_comb begin
      q_d        = q_q;
      cnt_d      = cnt_q;
      mode_lat_d = mode_lat_q;
      state_d    = state_q;

      if (load) begin
         q_d     = in;
         cnt_d   = '0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (amount == '0) begin
                     state_d = DONE;
                  end else begin
                     mode_lat_d = mode_t'(mode);
                     cnt_d      = (amount > MaxCnt) ? MaxCnt : amount;
                     state_d    = SHIFT;
                  end
               end else begin
                  q_d = step_q;
               end
            end
            SHIFT: begin
               q_d   = step_q;
               cnt_d = cnt_q - OneCnt;
               if (cnt_q == OneCnt) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q        <= '0;
         cnt_q      <= '0;
         mode_lat_q <= MODE_HOLD;
         state_q    <= IDLE;
      end else begin
         q_q        <= q_d;
         cnt_q      <= cnt_d;
         mode_lat_q <= mode_lat_d;
         state_q    <= state_d;
      end
   end

   assign q        = q_q;
   assign sout_msb = q_q[WIDTH-1];
   assign sout_lsb = q_q[0];
   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_param_shift_reg.sv
// Scoreboard bench for param_shift_reg (WIDTH=8): directed scenarios plus random traffic.
module tb_param_shift_reg;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] in_v;
   logic       sin;
   logic [2:0] mode;
   logic       start;
   logic [3:0] amount;
   logic [7:0] q;
   logic       sout_msb;
   logic       sout_lsb;
   logic       busy;
   logic       done;

   param_shift_reg #(
      .WIDTH (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .in       (in_v),
      .sin      (sin),
      .mode     (mode),
      .start    (start),
      .amount   (amount),
      .q        (q),
      .sout_msb (sout_msb),
      .sout_lsb (sout_lsb),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: register value, steps still owed, pending completion cycle
   int   m_q      = 0;
   int   m_left   = 0;
   int   m_mode   = 0;
   bit   m_in_dn  = 1'b0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int ref_step(input int v, input int md, input int s);
      case (md)
         1:       return (v * 2 + s) % 256;
         2:       return v / 2 + s * 128;
         3:       return (v * 2) % 256 + v / 128;
         4:       return v / 2 + (v % 2) * 128;
         5:       return v / 2 + ((v >= 128) ? 128 : 0);
         default: return v;
      endcase
   endfunction

   task automatic model_edge();
      int n;
      if (rst) begin
         m_q = 0; m_left = 0; m_in_dn = 1'b0;
      end else if (load) begin
         m_q = int'(in_v); m_left = 0; m_in_dn = 1'b0;
      end else if (m_in_dn) begin
         m_in_dn = 1'b0;
      end else if (m_left > 0) begin
         m_q = ref_step(m_q, m_mode, int'(sin));
         m_left--;
         if (m_left == 0) m_in_dn = 1'b1;
      end else if (start) begin
         n = (int'(amount) > 8) ? 8 : int'(amount);
         if (n == 0) m_in_dn = 1'b1;
         else begin
            m_left = n;
            m_mode = int'(mode);
         end
      end else begin
         m_q = ref_step(m_q, int'(mode), int'(sin));
      end
   endtask

   task automatic tick();
      exp_t e;
      model_edge();
      e.q    = 8'(m_q);
      e.busy = (m_left > 0);
      e.done = m_in_dn;
      @(posedge clk);
      exp_q.push_back(e);
      #2;
   endtask

   task automatic set_idle();
      rst = 1'b0; load = 1'b0; start = 1'b0; mode = 3'b000; sin = 1'b0; amount = 4'd0;
   endtask

   task automatic do_load(input logic [7:0] v);
      set_idle();
      load = 1'b1; in_v = v;
      tick();
      load = 1'b0;
   endtask

   // Monitor: every cycle is an output, compare against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_q", q, e.q);
         check("sb_busy", {7'd0, busy}, {7'd0, e.busy});
         check("sb_done", {7'd0, done}, {7'd0, e.done});
         check("sb_msb", {7'd0, sout_msb}, {7'd0, e.q[7]});
         check("sb_lsb", {7'd0, sout_lsb}, {7'd0, e.q[0]});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bc;
      in_v = 8'h00;
      set_idle();
      rst  = 1'b1;
      load = 1'b1; in_v = 8'hFF; start = 1'b1; amount = 4'd3;
      tick();
      tick();
      check("reset_q", q, 8'h00);
      check("reset_busy", {7'd0, busy}, 8'h00);
      check("reset_done", {7'd0, done}, 8'h00);

      // Parallel load
      do_load(8'hA5);
      check("load_q", q, 8'hA5);
      check("load_msb", {7'd0, sout_msb}, 8'h01);
      check("load_lsb", {7'd0, sout_lsb}, 8'h01);

      // Single-step SHL with sin=1
      mode = 3'b001; sin = 1'b1;
      tick(); check("shl1", q, 8'h4B);
      tick(); check("shl2", q, 8'h97);
      tick(); check("shl3", q, 8'h2F);

      // ROR burst of 4; live mode changed during burst must be ignored
      do_load(8'hA5);
      mode = 3'b100; amount = 4'd4; start = 1'b1;
      tick();
      start = 1'b0; mode = 3'b001; sin = 1'b1;
      bc = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         bc++;
         tick();
      end
      check("ror_busy_cycles", 8'(bc), 8'd4);
      check("ror_q", q, 8'h5A);
      check("ror_done", {7'd0, done}, 8'h01);
      mode = 3'b000;
      tick(); check("ror_done_pulse", {7'd0, done}, 8'h00);

      // ASR burst of 3 from 0x80
      do_load(8'h80);
      mode = 3'b101; amount = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("asr_q", q, 8'hF0);
      check("asr_done", {7'd0, done}, 8'h01);
      mode = 3'b000;
      tick();

      // Zero-length burst
      mode = 3'b001; amount = 4'd0; start = 1'b1;
      tick();
      check("zero_done", {7'd0, done}, 8'h01);
      check("zero_busy", {7'd0, busy}, 8'h00);
      check("zero_q", q, 8'hF0);
      start = 1'b0; mode = 3'b000;
      tick();

      // Load aborts a burst on its 2nd busy cycle
      do_load(8'hA5);
      mode = 3'b001; amount = 4'd6; start = 1'b1; sin = 1'b1;
      tick();
      start = 1'b0;
      tick();
      load = 1'b1; in_v = 8'h3C;
      tick();
      load = 1'b0; mode = 3'b000;
      check("abort_q", q, 8'h3C);
      check("abort_busy", {7'd0, busy}, 8'h00);
      tick();
      check("abort_no_done", {7'd0, done}, 8'h00);

      // Clamp amount 12 to 8 steps
      do_load(8'hFF);
      mode = 3'b001; sin = 1'b0; amount = 4'd12; start = 1'b1;
      tick();
      start = 1'b0;
      bc = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         bc++;
         tick();
      end
      check("clamp_busy_cycles", 8'(bc), 8'd8);
      check("clamp_q", q, 8'h00);
      mode = 3'b000;
      tick();

      // Reset on 3rd busy cycle
      do_load(8'h5A);
      mode = 3'b010; sin = 1'b1; amount = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; mode = 3'b000;
      check("rst_mid_q", q, 8'h00);
      check("rst_mid_busy", {7'd0, busy}, 8'h00);
      tick();
      check("rst_mid_no_done", {7'd0, done}, 8'h00);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 49) == 0);
         load   = ($urandom_range(0, 9) == 0);
         start  = ($urandom_range(0, 4) == 0);
         in_v   = 8'($urandom);
         sin    = 1'($urandom);
         mode   = 3'($urandom);
         amount = 4'($urandom);
         tick();
      end

      set_idle();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/param_shift_reg.md
PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), derived width of the burst amount and counter; not overridden.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 load  input  1  synchronous parallel load strobe.
REQ-006 in  input  WIDTH  parallel load data.
REQ-007 sin  input  1  serial input bit.
REQ-008 mode  input  3  operation select: 000 hold, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 ASR; 110 and 111 act as hold.
REQ-009 start  input  1  request a multi-step burst of `amount` steps.
REQ-010 amount  input  CNT_W  burst length in steps.
REQ-011 q  output  WIDTH  register contents.
REQ-012 sout_msb  output  1  q[WIDTH-1], the shift-left serial out.
REQ-013 sout_lsb  output  1  q[0], the shift-right serial out.
REQ-014 busy  output  1  high while the FSM is in SHIFT.
REQ-015 done  output  1  one-cycle pulse on burst completion.

Function
REQ-016 Step rules:
- SHL: q = {q[W-2:0], sin}.
- SHR: q = {sin, q[W-1:1]}.
- ROL: q = {q[W-2:0], q[W-1]}.
- ROR: q = {q[0], q[W-1:1]}.
- ASR: q = {q[W-1], q[W-1:1]}; sin is ignored.
REQ-017 FSM has three states: IDLE, SHIFT, DONE.
REQ-018 Per-edge priority is rst > load > burst logic > single-step mode.
REQ-019 IDLE, start=0: one step per edge according to mode (hold means q unchanged).
REQ-020 IDLE, start=1, amount>0: at edge k latch mode and min(amount, WIDTH) into the counter and go to SHIFT; no step on edge k.
REQ-021 SHIFT: one step per edge using the latched mode; sin is sampled on each step edge; the counter decrements each edge; the mode input is ignored.
REQ-022 A burst of N steps performs its steps on edges k+1..k+N, and busy is high for exactly N cycles.
REQ-023 On the last step, go to DONE.
REQ-024 DONE lasts one cycle: done=1, busy=0, q holds, then return to IDLE.
REQ-025 In DONE, start and mode are ignored.
REQ-026 IDLE, start=1, amount=0: go directly to DONE; no step is taken and busy never rises.
REQ-027 start while busy or in DONE is ignored; no queuing.
REQ-028 An amount greater than WIDTH is clamped to WIDTH.
REQ-029 load in any state: q=in at that edge and the FSM goes to IDLE; an aborted burst produces no done pulse.
REQ-030 load and start on the same edge: load wins and start is dropped.
REQ-031 sout_msb and sout_lsb are combinational from q, with zero latency.

Reset
REQ-032 rst=1 at an edge sets q=0, state=IDLE, counter=0, busy=0 and done=0, overriding load and start.
REQ-033 rst asserted mid-burst aborts the burst with no done pulse.

Structure
REQ-034 Package param_shift_pkg holds:
- the mode encodings (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR);
- the FSM state enum (IDLE, SHIFT, DONE).
REQ-035 Sub-module shift_step is purely combinational and computes the one-step next value from (q, mode, sin), parametrised by WIDTH.
REQ-036 param_shift_reg instantiates shift_step once.

Verification (WIDTH=8)
REQ-037 Reset, then load=1 with in=8'hA5 -> q=8'hA5 after one edge, sout_msb=1, sout_lsb=1.
REQ-038 From q=8'hA5, mode=SHL with sin=1 for 3 edges -> q=8'h4B, then 8'h97, then 8'h2F.
REQ-039 From q=8'hA5, start with mode=ROR and amount=4 -> busy high for 4 cycles, q=8'h5A, then done=1 for one cycle.
REQ-040 From q=8'h80, ASR burst with amount=3 -> q=8'hF0 with done pulse; separately, amount=0 -> done the next cycle, no busy, q unchanged.
REQ-041 SHL burst from 8'hA5 with amount=6 and load=1 (in=8'h3C) on the 2nd busy cycle -> q=8'h3C, busy low, no done pulse.
REQ-042 Boundary checks:
- amount=12 with SHL, sin=0, from 8'hFF -> 8 busy cycles, q=8'h00.
- rst on the 3rd busy cycle -> q=0, no done pulse.
